// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall, flush and forwarding control for the in-order MIPS pipeline
//
// Tracks in-flight register writers in a per-stage scoreboard (slot 1 = EX,
// slot PIPE_DEPTH = WB). From that scoreboard it raises a load-use/branch stall,
// squashes IF/ID on a taken redirect and registers EX-stage forwarding selects.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                core run enable (low: bubbles, no stall/flush)
//   id_*_i                 decoded ID-stage instruction and branch outcome
//   stall_o                hold PC and IF/ID, bubble into ID/EX (combinational)
//   flush_ifid_o           squash IF/ID (combinational)
//   fwd_a_o, fwd_b_o       EX operand source: 0 = ID/EX, k = output of slot k-1
//   stall_cnt_o            cycles with stall_o high (saturating)
//   flush_cnt_o            cycles with flush_ifid_o high (saturating)
module pipe_hazard_unit #(
  parameter  int REG_ADDR_W = 5,
  parameter  int PIPE_DEPTH = 3,
  parameter  int LOAD_STAGE = 2,
  parameter  int CNT_W      = 32,
  localparam int FWD_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_rs_used_i,
  input  logic                  id_rt_used_i,
  input  logic                  id_wr_en_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_is_load_i,
  input  logic                  id_is_branch_i,
  input  logic                  id_redirect_i,
  output logic                  stall_o,
  output logic                  flush_ifid_o,
  output logic [FWD_W-1:0]      fwd_a_o,
  output logic [FWD_W-1:0]      fwd_b_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  // Scoreboard: one entry per pipeline slot after ID.
  logic                  slot_valid_q [1:PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] slot_rd_q    [1:PIPE_DEPTH];
  logic                  slot_load_q  [1:PIPE_DEPTH];

  logic [FWD_W-1:0] fwd_a_q, fwd_b_q;
  logic [FWD_W-1:0] fwd_a_d, fwd_b_d;

  logic [PIPE_DEPTH:1] hit_a, hit_b;
  int               yng_a, yng_b;     // youngest matching slot, 0 = none
  logic             load_a, load_b;
  logic             branch_hit;
  logic             alu_stall;
  logic             active;
  logic             issue;

  // A slot matches a source only if it holds a real writer of a non-zero
  // register that the ID instruction actually reads.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      hit_a[k] = slot_valid_q[k] && (slot_rd_q[k] != '0) && id_rs_used_i
                 && (slot_rd_q[k] == id_rs_i);
      hit_b[k] = slot_valid_q[k] && (slot_rd_q[k] != '0) && id_rt_used_i
                 && (slot_rd_q[k] == id_rt_i);
    end
  end

  // Walk oldest to youngest so the lowest matching slot is the one kept.
  always_comb begin
    yng_a      = 0;
    yng_b      = 0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    branch_hit = 1'b0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (hit_a[k]) begin
        yng_a  = k;
        load_a = slot_load_q[k];
      end
      if (hit_b[k]) begin
        yng_b  = k;
        load_b = slot_load_q[k];
      end
      // Branches compare in ID with no forwarding; the WB slot is covered
      // by the write-through register file.
      if ((k <= PIPE_DEPTH - 1) && (hit_a[k] || hit_b[k])) begin
        branch_hit = 1'b1;
      end
    end
  end

  // A result is usable once the producer has passed its ready slot.
  always_comb begin
    alu_stall = 1'b0;
    if ((yng_a != 0) && (yng_a < (load_a ? LOAD_STAGE : 1))) alu_stall = 1'b1;
    if ((yng_b != 0) && (yng_b < (load_b ? LOAD_STAGE : 1))) alu_stall = 1'b1;
  end

  assign active       = id_valid_i & start_i;
  assign stall_o      = active & (alu_stall | (id_is_branch_i & branch_hit));
  assign flush_ifid_o = active & id_redirect_i & ~stall_o;
  assign issue        = active & ~stall_o;

  // Producer in slot k reaches the output of slot k's register next cycle,
  // which is EX mux input k+1; a WB-slot writer is read through the RF.
  always_comb begin
    fwd_a_d = '0;
    fwd_b_d = '0;
    if ((yng_a != 0) && (yng_a + 1 <= PIPE_DEPTH)) fwd_a_d = FWD_W'(yng_a + 1);
    if ((yng_b != 0) && (yng_b + 1 <= PIPE_DEPTH)) fwd_b_d = FWD_W'(yng_b + 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        slot_valid_q[k] <= 1'b0;
        slot_rd_q[k]    <= '0;
        slot_load_q[k]  <= 1'b0;
      end
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      for (int k = PIPE_DEPTH; k >= 2; k--) begin
        slot_valid_q[k] <= slot_valid_q[k-1];
        slot_rd_q[k]    <= slot_rd_q[k-1];
        slot_load_q[k]  <= slot_load_q[k-1];
      end
      slot_valid_q[1] <= issue & id_wr_en_i;
      slot_rd_q[1]    <= issue ? id_rd_i : '0;
      slot_load_q[1]  <= issue & id_is_load_i;
      fwd_a_q         <= issue ? fwd_a_d : '0;
      fwd_b_q         <= issue ? fwd_b_d : '0;
    end
  end

  assign fwd_a_o = fwd_a_q;
  assign fwd_b_o = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_ifid_o && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard controller for the in-order pipelined MIPS core. It tracks in-flight register writers in a per-stage scoreboard shift register and, each cycle, issues three things: a load-use/branch stall, an IF/ID flush for taken branches/jumps, and registered forwarding selects for the EX-stage operand muxes. It sits beside the ID stage and is fed from the decoder, the control unit and the ID-stage branch comparator. It removes the need for software NOPs.

## Interface
- REG_ADDR_W, 5: register index width.
- PIPE_DEPTH, 3: stages after ID tracked (slot 1 = EX, slot PIPE_DEPTH = WB); legal ≥2.
- LOAD_STAGE, 2: slot whose output first carries load data; legal 1..PIPE_DEPTH-1.
- CNT_W, 32: performance counter width.
- FWD_W, $clog2(PIPE_DEPTH+1): forward select width (derived, not overridden).

Ports:
- clk_i  in  1  clock. One clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  core run enable; low = insert bubbles, no stall/flush.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i / id_rt_i  in  REG_ADDR_W  source indices.
- id_rs_used_i / id_rt_used_i  in  1  source actually read.
- id_wr_en_i  in  1  instruction writes a register.
- id_rd_i  in  REG_ADDR_W  destination (already RegDst-muxed).
- id_is_load_i  in  1  instruction is lw.
- id_is_branch_i  in  1  instruction compares operands in ID.
- id_redirect_i  in  1  taken branch or jump resolved in ID.
- stall_o  out  1  hold PC and IF/ID, bubble into ID/EX.
- flush_ifid_o  out  1  squash IF/ID contents.
- fwd_a_o / fwd_b_o  out  FWD_W  EX operand source: 0 = ID/EX register value, k = output of slot k-1's pipeline register (2 = EX/MEM, 3 = MEM/WB).
- stall_cnt_o / flush_cnt_o  out  CNT_W  performance counters.

## Operation
- Scoreboard: slots 1..PIPE_DEPTH, each {valid, rd, is_load}. Each cycle slot k+1 ← slot k; slot PIPE_DEPTH retires. Slot 1 ← ID info when issue = id_valid_i & start_i & ~stall_o, else bubble (valid=0).
- Match: slot valid & rd ≠ 0 & rd equals a used source. For each source, only the youngest matching slot (lowest k) counts.
- Ready stage: LOAD_STAGE for loads, 1 otherwise.
- ALU stall: youngest match at slot k with k < ready stage.
- Branch stall: id_is_branch_i and any match in slots 1..PIPE_DEPTH-1. No forwarding into ID. A slot-PIPE_DEPTH writer is covered by the write-through register file.
- stall_o = id_valid_i & start_i & (ALU stall | branch stall).
- flush_ifid_o = id_valid_i & start_i & id_redirect_i & ~stall_o. If stall and redirect coincide, the stall wins and the redirect is re-evaluated next cycle.
- Forward: on issue, fwd_x_o ← k+1 for the youngest match at slot k with k+1 ≤ PIPE_DEPTH, else 0. On a bubble, fwd_x_o ← 0.
- rd = 0 never matches. An unused source never matches.
- start_i low: bubbles shift in, stall_o = flush_ifid_o = 0, counters hold.

## Timing
- stall_o and flush_ifid_o are combinational from ID inputs and the registered scoreboard, valid in the same cycle.
- fwd_*_o are registered and valid during the consumer's EX cycle, one cycle after issue.
- Stall length:
  - load-use: LOAD_STAGE − k cycles;
  - branch after ALU op: PIPE_DEPTH − k cycles.
- Reset: all slots invalid; fwd_a_o = fwd_b_o = 0; stall_o = flush_ifid_o = 0 from the first cycle after reset; counters 0. Reset mid-stall aborts the stall with no residual state.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt_o increments on each cycle with stall_o = 1, and flush_cnt_o on each cycle with flush_ifid_o = 1. Both saturate at 2^CNT_W−1 and clear on reset.
- Undefined: counter registers are not built; both outputs are tied to 0.

## Test plan
- add $1,$2,$3 then add $4,$1,$1 back-to-back: no stall; fwd_a_o = fwd_b_o = 2 in the consumer's EX cycle.
- lw $1,0($0) then add $3,$1,$0: stall_o = 1 for exactly 1 cycle, then issue with fwd_a_o = 3, fwd_b_o = 0; stall_cnt_o = 1.
- add $1 then beq $1,$0 taken: stall_o = 1 for 2 cycles, then flush_ifid_o = 1 for 1 cycle; flush_cnt_o = 1.
- add $0,$2,$3 then add $4,$0,$0: no stall; fwd 0/0.
- add $1; add $1; add $4,$1,$5: youngest writer wins, fwd_a_o = 2, fwd_b_o = 0.
- rst_i asserted during a load-use stall: next cycle stall_o = 0, scoreboard empty, fwd 0, counters 0. The same add then issues with no stall.
